// File: rtl/lap_timer_ctrl_pkg.sv
// Shared race timing types and constants for the lap timer block.
package race_pkg;

  localparam int TIME_W      = 16;
  localparam int MAX_TIME_CS = 59999;
  localparam int LAPCNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    PAUSED   = 2'd2,
    FINISHED = 2'd3
  } race_state_t;

  // Increment that sticks at max_t instead of wrapping.
  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] t,
                                                input logic [TIME_W-1:0] max_t);
    logic [TIME_W-1:0] r;
    if (t >= max_t) r = max_t;
    else            r = t + TIME_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/lap_timer_ctrl_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and pulses tick_o on the wrap cycle.
module tick_gen #(
  parameter int DIV = 650000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lap_timer_ctrl.sv
// Race lap timer: running lap time, last/best lap and lap count, with a
// start/pause/finish sequencer. All outputs come straight from registers.
module lap_timer_ctrl #(
  parameter int CLK_FREQ_HZ = 65_000_000,
  parameter int TICK_HZ     = 100,
  parameter int MAX_TIME_CS = race_pkg::MAX_TIME_CS,
  parameter int MIN_LAP_CS  = 200,
  parameter int NUM_LAPS    = 3
) (
  input  logic                        pclk,
  input  logic                        rst,
  input  logic                        race_start,
  input  logic                        pause,
  input  logic                        lap_cross,
  output logic [race_pkg::TIME_W-1:0] lap_time,
  output logic [race_pkg::TIME_W-1:0] last_lap_time,
  output logic [race_pkg::TIME_W-1:0] best_lap_time,
  output logic                        best_valid,
  output logic                        new_best,
  output logic [race_pkg::LAPCNT_W-1:0] lap_count,
  output logic                        race_done
);
  import race_pkg::*;

  localparam int                  DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam logic [TIME_W-1:0]   MAX_T = TIME_W'(MAX_TIME_CS);
  localparam logic [TIME_W-1:0]   MIN_T = TIME_W'(MIN_LAP_CS);
  localparam logic [LAPCNT_W-1:0] NUM_L = LAPCNT_W'(NUM_LAPS);

  race_state_t state_q, state_d;

  logic [TIME_W-1:0]   lap_q, lap_d;
  logic [TIME_W-1:0]   last_q, last_d;
  logic [TIME_W-1:0]   best_q, best_d;
  logic                best_valid_q, best_valid_d;
  logic                new_best_q, new_best_d;
  logic [LAPCNT_W-1:0] cnt_q, cnt_d;
  logic                done_q, done_d;

  logic                tick;
  logic                presc_en;
  logic                lap_ok;
  logic [LAPCNT_W-1:0] cnt_inc;

  assign presc_en = (state_q == RUNNING) && !pause && !race_start;
  assign lap_ok   = (state_q == RUNNING) && lap_cross && (lap_q >= MIN_T);
  assign cnt_inc  = cnt_q + LAPCNT_W'(1);

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk_i  (pclk),
    .rst_i  (rst),
    .en_i   (presc_en),
    .clr_i  (race_start),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    if (race_start) begin
      state_d = RUNNING;
    end else begin
      case (state_q)
        IDLE:     state_d = IDLE;
        RUNNING: begin
          // Finishing lap wins over a pause requested in the same cycle.
          if (lap_ok && (cnt_inc == NUM_L)) state_d = FINISHED;
          else if (pause)                   state_d = PAUSED;
        end
        PAUSED:   if (!pause) state_d = RUNNING;
        FINISHED: state_d = FINISHED;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    lap_d        = lap_q;
    last_d       = last_q;
    best_d       = best_q;
    best_valid_d = best_valid_q;
    new_best_d   = 1'b0;
    cnt_d        = cnt_q;
    if (race_start) begin
      lap_d  = '0;
      last_d = '0;
      cnt_d  = '0;
    end else if (lap_ok) begin
      // A tick landing on the closing cycle is dropped; the new lap starts at 0.
      last_d = lap_q;
      lap_d  = '0;
      cnt_d  = cnt_inc;
      if (!best_valid_q || (lap_q < best_q)) begin
        best_d       = lap_q;
        best_valid_d = 1'b1;
        new_best_d   = 1'b1;
      end
    end else if (tick) begin
      lap_d = sat_inc(lap_q, MAX_T);
    end
    done_d = (state_d == FINISHED);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= IDLE;
      lap_q        <= '0;
      last_q       <= '0;
      best_q       <= '0;
      best_valid_q <= 1'b0;
      new_best_q   <= 1'b0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lap_q        <= lap_d;
      last_q       <= last_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
      new_best_q   <= new_best_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
    end
  end

  assign lap_time      = lap_q;
  assign last_lap_time = last_q;
  assign best_lap_time = best_q;
  assign best_valid    = best_valid_q;
  assign new_best      = new_best_q;
  assign lap_count     = cnt_q;
  assign race_done     = done_q;

endmodule

// File: tb/tb_lap_timer_ctrl.sv
// Bench for lap_timer_ctrl: directed vector table, randomized run against a
// behavioural model, and a saturation run on a one-tick-per-clock instance.
module tb_lap_timer_ctrl;

  localparam int DIV1  = 10;
  localparam int MINL  = 5;
  localparam int NUML  = 3;
  localparam int MAXT  = 59999;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        rst = 1'b0, race_start = 1'b0, pause = 1'b0, lap_cross = 1'b0;
  logic [15:0] lap_time, last_lap_time, best_lap_time;
  logic        best_valid, new_best, race_done;
  logic [3:0]  lap_count;

  logic        s_rst = 1'b1, s_rs = 1'b0, s_pz = 1'b0, s_lc = 1'b0;
  logic [15:0] s_lap, s_last, s_best;
  logic        s_bv, s_nb, s_done;
  logic [3:0]  s_cnt;

  lap_timer_ctrl #(.CLK_FREQ_HZ(1000), .TICK_HZ(100), .MIN_LAP_CS(MINL), .NUM_LAPS(NUML)) dut (
    .pclk(pclk), .rst(rst), .race_start(race_start), .pause(pause), .lap_cross(lap_cross),
    .lap_time(lap_time), .last_lap_time(last_lap_time), .best_lap_time(best_lap_time),
    .best_valid(best_valid), .new_best(new_best), .lap_count(lap_count), .race_done(race_done));

  lap_timer_ctrl #(.CLK_FREQ_HZ(100), .TICK_HZ(100), .MIN_LAP_CS(MINL), .NUM_LAPS(NUML)) u_sat (
    .pclk(pclk), .rst(s_rst), .race_start(s_rs), .pause(s_pz), .lap_cross(s_lc),
    .lap_time(s_lap), .last_lap_time(s_last), .best_lap_time(s_best),
    .best_valid(s_bv), .new_best(s_nb), .lap_count(s_cnt), .race_done(s_done));

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
  endtask

  // Behavioural reference: race phase flags plus cycles-since-last-tick.
  int m_lap, m_last, m_best, m_cnt, m_ph;
  bit m_bv, m_nb, m_live, m_paused, m_done;

  task automatic model_update();
    bit tk;
    tk = 1'b0;
    m_nb = 1'b0;
    if (rst) begin
      m_lap = 0; m_last = 0; m_best = 0; m_cnt = 0; m_ph = 0;
      m_bv = 0; m_live = 0; m_paused = 0; m_done = 0;
    end else if (race_start) begin
      m_live = 1; m_paused = 0; m_done = 0;
      m_lap = 0; m_last = 0; m_cnt = 0; m_ph = 0;
    end else if (m_live && !m_done) begin
      if (m_paused) begin
        if (!pause) m_paused = 0;
      end else begin
        if (!pause) begin
          m_ph++;
          if (m_ph == DIV1) begin m_ph = 0; tk = 1'b1; end
        end
        if (lap_cross && m_lap >= MINL) begin
          m_last = m_lap;
          if (!m_bv || m_lap < m_best) begin m_best = m_lap; m_bv = 1; m_nb = 1; end
          m_lap = 0;
          m_cnt++;
          if (m_cnt == NUML) m_done = 1;
          else if (pause)    m_paused = 1;
        end else begin
          if (tk) m_lap = (m_lap + 1 > MAXT) ? MAXT : m_lap + 1;
          if (pause) m_paused = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge pclk);
    model_update();
    #1;
  endtask

  typedef struct {
    string name;
    int    ncyc;
    bit    r, rs, pz, lc;
    int    lap, last, best;
    bit    bv, nb;
    int    cnt;
    bit    done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input int ncyc, input bit r, input bit rs, input bit pz,
                     input bit lc, input int lap, input int last, input int best, input bit bv,
                     input bit nb, input int cnt, input bit done);
    vec_t v;
    v.name = name; v.ncyc = ncyc; v.r = r; v.rs = rs; v.pz = pz; v.lc = lc;
    v.lap = lap; v.last = last; v.best = best; v.bv = bv; v.nb = nb; v.cnt = cnt; v.done = done;
    tbl.push_back(v);
  endtask

  function automatic longint pack_dut();
    return {lap_time, last_lap_time, best_lap_time, best_valid, new_best, lap_count, race_done};
  endfunction

  function automatic longint pack_model();
    logic [15:0] a, b, c;
    logic [3:0]  n;
    a = 16'(m_lap); b = 16'(m_last); c = 16'(m_best); n = 4'(m_cnt);
    return {a, b, c, m_bv, m_nb, n, m_done};
  endfunction

  int prev, nwrap;

  initial begin
    //   name          ncyc r rs pz lc  lap last best bv nb cnt done
    add("reset",        1,  1, 0, 0, 0,   0,   0,   0, 0, 0, 0, 0);
    add("idle",        20,  0, 0, 0, 0,   0,   0,   0, 0, 0, 0, 0);
    add("start",        1,  0, 1, 0, 0,   0,   0,   0, 0, 0, 0, 0);
    add("run100",     100,  0, 0, 0, 0,  10,   0,   0, 0, 0, 0, 0);
    add("run120",      20,  0, 0, 0, 0,  12,   0,   0, 0, 0, 0, 0);
    add("lap12",        1,  0, 0, 0, 1,   0,  12,  12, 1, 1, 1, 0);
    add("nb_drop",      1,  0, 0, 0, 0,   0,  12,  12, 1, 0, 1, 0);
    add("run15",      148,  0, 0, 0, 0,  15,  12,  12, 1, 0, 1, 0);
    add("lap15",        1,  0, 0, 0, 1,   0,  15,  12, 1, 0, 2, 0);
    add("run9",        89,  0, 0, 0, 0,   9,  15,  12, 1, 0, 2, 0);
    add("lap9",         1,  0, 0, 0, 1,   0,   9,   9, 1, 1, 3, 1);
    add("fin_hold",     1,  0, 0, 0, 0,   0,   9,   9, 1, 0, 3, 1);
    add("fin_cross",    1,  0, 0, 0, 1,   0,   9,   9, 1, 0, 3, 1);
    add("fin_idle",    50,  0, 0, 0, 0,   0,   9,   9, 1, 0, 3, 1);
    add("restart",      1,  0, 1, 0, 0,   0,   0,   9, 1, 0, 0, 0);
    add("run30",       30,  0, 0, 0, 0,   3,   0,   9, 1, 0, 0, 0);
    add("short3",       1,  0, 0, 0, 1,   3,   0,   9, 1, 0, 0, 0);
    add("pause_in",     1,  0, 0, 1, 0,   3,   0,   9, 1, 0, 0, 0);
    add("paused",      40,  0, 0, 1, 0,   3,   0,   9, 1, 0, 0, 0);
    add("pause_cross",  1,  0, 0, 1, 1,   3,   0,   9, 1, 0, 0, 0);
    add("unpause",      1,  0, 0, 0, 0,   3,   0,   9, 1, 0, 0, 0);
    add("run8",         8,  0, 0, 0, 0,   3,   0,   9, 1, 0, 0, 0);
    add("run1",         1,  0, 0, 0, 0,   4,   0,   9, 1, 0, 0, 0);
    add("short4",       1,  0, 0, 0, 1,   4,   0,   9, 1, 0, 0, 0);
    add("run9b",        9,  0, 0, 0, 0,   5,   0,   9, 1, 0, 0, 0);
    add("lap5",         1,  0, 0, 0, 1,   0,   5,   5, 1, 1, 1, 0);
    add("run30b",      30,  0, 0, 0, 0,   3,   5,   5, 1, 0, 1, 0);
    add("start_cross",  1,  0, 1, 0, 1,   0,   0,   5, 1, 0, 0, 0);
    add("rst_mid",      1,  1, 0, 0, 0,   0,   0,   0, 0, 0, 0, 0);

    #2;
    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].ncyc; c++) begin
        rst        = tbl[i].r  && (c == 0);
        race_start = tbl[i].rs && (c == 0);
        lap_cross  = tbl[i].lc && (c == 0);
        pause      = tbl[i].pz;
        step();
      end
      rst = 0; race_start = 0; lap_cross = 0;
      check($sformatf("%s.lap_time", tbl[i].name),   lap_time,      tbl[i].lap);
      check($sformatf("%s.last", tbl[i].name),       last_lap_time, tbl[i].last);
      check($sformatf("%s.best", tbl[i].name),       best_lap_time, tbl[i].best);
      check($sformatf("%s.best_valid", tbl[i].name), best_valid,    tbl[i].bv);
      check($sformatf("%s.new_best", tbl[i].name),   new_best,      tbl[i].nb);
      check($sformatf("%s.lap_count", tbl[i].name),  lap_count,     tbl[i].cnt);
      check($sformatf("%s.race_done", tbl[i].name),  race_done,     tbl[i].done);
    end

    // Randomized traffic against the model.
    pause = 0; rst = 1; step(); rst = 0;
    for (int k = 0; k < 8000; k++) begin
      rst        = ($urandom_range(0, 1999) == 0);
      race_start = ($urandom_range(0, 599) == 0);
      lap_cross  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) pause = ~pause;
      step();
      check($sformatf("rand[%0d]", k), pack_dut(), pack_model());
    end
    rst = 0; race_start = 0; lap_cross = 0; pause = 0;

    // Saturation: one tick per clock on u_sat.
    s_rst = 1; step(); s_rst = 0;
    s_rs = 1; step(); s_rs = 0;
    check("sat.start", s_lap, 0);
    prev = 0; nwrap = 0;
    for (int k = 1; k <= 60010; k++) begin
      step();
      if (int'(s_lap) < prev) nwrap++;
      prev = int'(s_lap);
      if (k == 59998) check("sat.59998", s_lap, 59998);
      if (k == 59999) check("sat.59999", s_lap, 59999);
    end
    check("sat.hold", s_lap, 59999);
    check("sat.no_wrap", nwrap, 0);
    s_lc = 1; step(); s_lc = 0;
    check("sat.lap_last", s_last, 59999);
    check("sat.lap_best", s_best, 59999);
    check("sat.lap_count", s_cnt, 1);
    check("sat.lap_reset", s_lap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
